input_matrix_scanner: RTL and testbench

//  Generalised, parametrised successor of the K-input mapper. Debounces raw pad buttons, maps them through
//  per-strobe config codes onto the MPU K lines for any strobe count / K width, and adds a grounded row,
//  aux inputs (beta/BA/ACL) and a K wake pulse for halted CPUs. Sits between the core's pad inputs and the
//  SM5xx MPU; the CPU-specific strobe source (S shifter vs R lines) is selected by the caller.

---
 rtl/input_matrix_scanner_pkg.sv | 67 ++++++
 rtl/input_matrix_scanner_if.sv | 23 ++
 rtl/input_matrix_scanner_debouncer.sv | 50 +++++
 rtl/input_matrix_scanner.sv | 93 +++++++++
 tb/tb_input_matrix_scanner.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/input_matrix_scanner_pkg.sv
// rtl/input_matrix_scanner_pkg.sv - button codes, button bit positions and code decoder
// Shared by the scanner and the config loader so both agree on what a code selects.
package input_matrix_scanner_pkg;

  localparam logic [6:0] CODE_DPAD_UP    = 7'd0;
  localparam logic [6:0] CODE_DPAD_DOWN  = 7'd1;
  localparam logic [6:0] CODE_DPAD_LEFT  = 7'd2;
  localparam logic [6:0] CODE_DPAD_RIGHT = 7'd3;
  localparam logic [6:0] CODE_B          = 7'd4;
  localparam logic [6:0] CODE_A          = 7'd5;
  localparam logic [6:0] CODE_Y          = 7'd6;
  localparam logic [6:0] CODE_X          = 7'd7;
  localparam logic [6:0] CODE_TRIG_L     = 7'd12;
  localparam logic [6:0] CODE_SELECT     = 7'd13;
  localparam logic [6:0] CODE_START      = 7'd14;
  localparam logic [6:0] CODE_TRIG_R     = 7'd16;
  localparam logic [6:0] CODE_DPAD2_UP   = 7'd17;
  localparam logic [6:0] CODE_DPAD2_DOWN = 7'd18;
  localparam logic [6:0] CODE_DPAD2_LEFT = 7'd19;
  localparam logic [6:0] CODE_DPAD2_RIGHT= 7'd20;
  localparam logic [6:0] CODE_X2         = 7'd21;
  localparam logic [6:0] CODE_B2         = 7'd22;
  localparam logic [6:0] CODE_Y2         = 7'd23;
  localparam logic [6:0] CODE_A2         = 7'd24;
  localparam logic [6:0] CODE_UNUSED     = 7'h7F;

  localparam logic [3:0] BTN_UP     = 4'd0;
  localparam logic [3:0] BTN_DOWN   = 4'd1;
  localparam logic [3:0] BTN_LEFT   = 4'd2;
  localparam logic [3:0] BTN_RIGHT  = 4'd3;
  localparam logic [3:0] BTN_A      = 4'd4;
  localparam logic [3:0] BTN_B      = 4'd5;
  localparam logic [3:0] BTN_X      = 4'd6;
  localparam logic [3:0] BTN_Y      = 4'd7;
  localparam logic [3:0] BTN_TRIG_L = 4'd8;
  localparam logic [3:0] BTN_TRIG_R = 4'd9;
  localparam logic [3:0] BTN_START  = 4'd10;
  localparam logic [3:0] BTN_SELECT = 4'd11;

  typedef struct packed {
    logic       valid;
    logic [3:0] index;
  } btn_sel_t;

  function automatic btn_sel_t code_to_button(input logic [6:0] code);
    btn_sel_t sel;
    sel.valid = 1'b1;
    sel.index = BTN_UP;
    case (code)
      CODE_DPAD_UP,    CODE_DPAD2_UP:    sel.index = BTN_UP;
      CODE_DPAD_DOWN,  CODE_DPAD2_DOWN:  sel.index = BTN_DOWN;
      CODE_DPAD_LEFT,  CODE_DPAD2_LEFT:  sel.index = BTN_LEFT;
      CODE_DPAD_RIGHT, CODE_DPAD2_RIGHT: sel.index = BTN_RIGHT;
      CODE_A,          CODE_A2:          sel.index = BTN_A;
      CODE_B,          CODE_B2:          sel.index = BTN_B;
      CODE_X,          CODE_X2:          sel.index = BTN_X;
      CODE_Y,          CODE_Y2:          sel.index = BTN_Y;
      CODE_TRIG_L:                       sel.index = BTN_TRIG_L;
      CODE_TRIG_R:                       sel.index = BTN_TRIG_R;
      CODE_START:                        sel.index = BTN_START;
      CODE_SELECT:                       sel.index = BTN_SELECT;
      default:                           sel.valid = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/input_matrix_scanner_if.sv
// rtl/input_matrix_scanner_if.sv - strobe/K-line bundle between the scanner and the MPU
// The MPU drives the row strobes and samples K plus the aux lines.
interface input_matrix_scanner_if #(
  parameter int NUM_STROBES = 8,
  parameter int K_WIDTH     = 4
);
  logic [NUM_STROBES-1:0] strobe;
  logic [K_WIDTH-1:0]     input_k;
  logic                   input_beta;
  logic                   input_ba;
  logic                   input_acl;
  logic                   k_wake;

  modport scanner (
    input  strobe,
    output input_k, input_beta, input_ba, input_acl, k_wake
  );

  modport mpu (
    output strobe,
    input  input_k, input_beta, input_ba, input_acl, k_wake
  );
endinterface

// File: rtl/input_matrix_scanner_debouncer.sv
// rtl/input_matrix_scanner_debouncer.sv - single-button synchroniser and stability debouncer
// A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples; 0 bypasses.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_raw,
  output logic button_db
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    sync1_d  = button_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    count_d  = '0;
    if (DEBOUNCE_CYCLES == 0) begin
      stable_d = sync2_q;
    end else if (sync2_q != stable_q) begin
      // Any sample matching the stable value falls through with count_d = 0.
      if (count_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      count_q  <= count_d;
    end
  end

  assign button_db = stable_q;
endmodule

// File: rtl/input_matrix_scanner.sv
// rtl/input_matrix_scanner.sv - debounced pad buttons mapped through per-strobe codes onto MPU K lines
// Two register stages: strobe-qualified row OR plus grounded row, then the combined K and wake detect.
module input_matrix_scanner
  import input_matrix_scanner_pkg::*;
#(
  parameter int NUM_STROBES     = 8,
  parameter int K_WIDTH         = 4,
  parameter int NUM_BUTTONS     = 12,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_STROBES*K_WIDTH*8-1:0]   row_config,
  input  logic [3:0]                         grounded_row,
  input  logic [23:0]                        aux_config,
  input  logic [NUM_BUTTONS-1:0]             buttons_raw,
  input_matrix_scanner_if.scanner            mpu
);
  logic [NUM_BUTTONS-1:0] btn_db;

  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_db
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk        (clk),
      .reset_n    (reset_n),
      .button_raw (buttons_raw[b]),
      .button_db  (btn_db[b])
    );
  end

  function automatic logic map_code(input logic [7:0] code, input logic [NUM_BUTTONS-1:0] btn);
    btn_sel_t sel;
    logic     hit;
    sel = code_to_button(code[6:0]);
    hit = 1'b0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (sel.valid && int'(sel.index) == i) hit = btn[i];
    end
    return hit ^ code[7];
  endfunction

  logic [K_WIDTH-1:0] row_map [NUM_STROBES];
  logic [K_WIDTH-1:0] main_k_q, main_k_d;
  logic [K_WIDTH-1:0] ground_k_q, ground_k_d;
  logic [K_WIDTH-1:0] input_k_q, input_k_d;
  logic               k_wake_q, k_wake_d;
  logic               beta_q, beta_d;
  logic               ba_q, ba_d;
  logic               acl_q, acl_d;

  always_comb begin
    main_k_d   = '0;
    ground_k_d = '0;
    for (int r = 0; r < NUM_STROBES; r++) begin
      for (int k = 0; k < K_WIDTH; k++) begin
        row_map[r][k] = map_code(row_config[(r*K_WIDTH+k)*8 +: 8], btn_db);
      end
      if (mpu.strobe[r]) main_k_d = main_k_d | row_map[r];
      // grounded_row is 1-based; 0 and rows past NUM_STROBES never match.
      if (int'(grounded_row) == r + 1) ground_k_d = row_map[r];
    end
    input_k_d = main_k_q | ground_k_q;
    k_wake_d  = (input_k_q == '0) && (input_k_d != '0);
    beta_d    = map_code(aux_config[7:0],   btn_db);
    ba_d      = map_code(aux_config[15:8],  btn_db);
    acl_d     = map_code(aux_config[23:16], btn_db);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_k_q   <= '0;
      ground_k_q <= '0;
      input_k_q  <= '0;
      k_wake_q   <= 1'b0;
      beta_q     <= 1'b0;
      ba_q       <= 1'b0;
      acl_q      <= 1'b0;
    end else begin
      main_k_q   <= main_k_d;
      ground_k_q <= ground_k_d;
      input_k_q  <= input_k_d;
      k_wake_q   <= k_wake_d;
      beta_q     <= beta_d;
      ba_q       <= ba_d;
      acl_q      <= acl_d;
    end
  end

  assign mpu.input_k    = input_k_q;
  assign mpu.k_wake     = k_wake_q;
  assign mpu.input_beta = beta_q;
  assign mpu.input_ba   = ba_q;
  assign mpu.input_acl  = acl_q;
endmodule

// File: tb/tb_input_matrix_scanner.sv
// tb/tb_input_matrix_scanner.sv - directed and randomized checks of the scanner against a cycle model
module tb_input_matrix_scanner;
  localparam int NS = 8;
  localparam int KW = 4;
  localparam int NB = 12;
  localparam int D  = 16;
  localparam int MAXC = 4000;
  localparam int N0 = 24;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NS*KW*8-1:0] row_config;
  logic [3:0]      grounded_row;
  logic [23:0]     aux_config;
  logic [NB-1:0]   buttons_raw;

  input_matrix_scanner_if #(.NUM_STROBES(NS), .K_WIDTH(KW)) bus ();

  input_matrix_scanner #(
    .NUM_STROBES(NS), .K_WIDTH(KW), .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .row_config   (row_config),
    .grounded_row (grounded_row),
    .aux_config   (aux_config),
    .buttons_raw  (buttons_raw),
    .mpu          (bus.scanner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n        = N0;

  logic          rst_h   [MAXC];
  logic [NB-1:0] eff_raw [MAXC];
  logic [NB-1:0] samp    [MAXC];
  logic [NB-1:0] deb     [MAXC];
  logic [KW-1:0] ek      [MAXC];

  logic [NS-1:0]      prev_strobe;
  logic [NS*KW*8-1:0] prev_cfg;
  logic [3:0]         prev_gr;

  function automatic logic map_code(input logic [7:0] c, input logic [NB-1:0] b);
    logic v;
    case (int'(c[6:0]))
      0, 17:   v = b[0];
      1, 18:   v = b[1];
      2, 19:   v = b[2];
      3, 20:   v = b[3];
      5, 24:   v = b[4];
      4, 22:   v = b[5];
      7, 21:   v = b[6];
      6, 23:   v = b[7];
      12:      v = b[8];
      16:      v = b[9];
      14:      v = b[10];
      13:      v = b[11];
      default: v = 1'b0;
    endcase
    return v ^ c[7];
  endfunction

  // K is simply the OR of every row that is strobed or grounded.
  function automatic logic [KW-1:0] model_k(input logic [NS-1:0] s, input logic [NS*KW*8-1:0] cfg,
                                            input logic [3:0] gr, input logic [NB-1:0] b);
    logic [KW-1:0] k;
    k = '0;
    for (int r = 0; r < NS; r++) begin
      if (s[r] || (gr != 0 && int'(gr) - 1 == r)) begin
        for (int j = 0; j < KW; j++) k[j] = k[j] | map_code(cfg[(r*KW+j)*8 +: 8], b);
      end
    end
    return k;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: got %h expected %h", tag, n, obs, exp);
  endtask

  task automatic step();
    logic [2:0] eaux;
    logic       ewake;
    logic       all_same;
    @(posedge clk);
    #1;
    rst_h[n]   = !reset_n;
    eff_raw[n] = rst_h[n] ? '0 : buttons_raw;
    samp[n]    = rst_h[n-1] ? '0 : eff_raw[n-2];
    if (rst_h[n]) begin
      deb[n] = '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        all_same = 1'b1;
        for (int j = 0; j < D; j++) if (samp[n-j][b] !== samp[n][b]) all_same = 1'b0;
        if (D == 0) deb[n][b] = samp[n][b];
        else if (all_same && samp[n][b] != deb[n-1][b]) deb[n][b] = samp[n][b];
        else deb[n][b] = deb[n-1][b];
      end
    end
    ek[n] = (rst_h[n] || rst_h[n-1]) ? '0 : model_k(prev_strobe, prev_cfg, prev_gr, deb[n-2]);
    eaux  = rst_h[n] ? 3'b000 : {map_code(aux_config[23:16], deb[n-1]),
                                 map_code(aux_config[15:8],  deb[n-1]),
                                 map_code(aux_config[7:0],   deb[n-1])};
    ewake = rst_h[n] ? 1'b0 : (ek[n-1] == '0 && ek[n] != '0);
    check("k",    32'(bus.input_k), 32'(ek[n]));
    check("aux",  32'({bus.input_acl, bus.input_ba, bus.input_beta}), 32'(eaux));
    check("wake", 32'(bus.k_wake), 32'(ewake));
    prev_strobe = bus.strobe;
    prev_cfg    = row_config;
    prev_gr     = grounded_row;
    n++;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NS*KW; i++) row_config[i*8 +: 8] = 8'h7F;
  endtask

  task automatic set_code(input int r, input int k, input logic [7:0] c);
    row_config[(r*KW+k)*8 +: 8] = c;
  endtask

  function automatic logic [7:0] rand_code();
    int srcs [21] = '{0, 1, 2, 3, 4, 5, 6, 7, 12, 13, 14, 16, 17, 18, 19, 20, 21, 22, 23, 24, 8};
    logic [7:0] c;
    if ($urandom_range(0, 9) < 4) c = 8'h7F;
    else c = 8'(srcs[$urandom_range(0, 20)]);
    if ($urandom_range(0, 7) == 0) c[7] = 1'b1;
    return c;
  endfunction

  task automatic randomize_cfg();
    for (int r = 0; r < NS; r++)
      for (int k = 0; k < KW; k++) set_code(r, k, rand_code());
  endtask

  initial begin
    logic wake_seen;
    for (int i = 0; i < N0; i++) begin
      rst_h[i] = 1'b1; eff_raw[i] = '0; samp[i] = '0; deb[i] = '0; ek[i] = '0;
    end
    reset_n      = 1'b0;
    buttons_raw  = '1;
    bus.strobe   = '1;
    clear_cfg();
    grounded_row = 4'd0;
    aux_config   = {8'h0E, 8'h85, 8'h07};
    prev_strobe  = '0;
    prev_cfg     = row_config;
    prev_gr      = '0;

    repeat (3) step();
    check("reset_k",    32'(bus.input_k), 32'd0);
    check("reset_wake", 32'(bus.k_wake), 32'd0);
    check("reset_aux",  32'({bus.input_acl, bus.input_ba, bus.input_beta}), 32'd0);
    buttons_raw = '0;
    bus.strobe  = '0;
    reset_n     = 1'b1;
    repeat (4) step();

    // a held, row0 bit0 = a
    set_code(0, 0, 8'h05);
    bus.strobe = 8'h01;
    repeat (3) step();
    buttons_raw[4] = 1'b1;
    repeat (19) step();
    check("t1_early", 32'(bus.input_k), 32'h0);
    step();
    check("t1_k",    32'(bus.input_k), 32'h1);
    check("t1_wake", 32'(bus.k_wake), 32'h1);
    step();
    check("t1_wake_once", 32'(bus.k_wake), 32'h0);
    buttons_raw[4] = 1'b0;
    repeat (25) step();

    // 10-cycle glitch on dpad up
    set_code(0, 0, 8'h00);
    repeat (3) step();
    buttons_raw[0] = 1'b1;
    repeat (10) step();
    buttons_raw[0] = 1'b0;
    wake_seen = 1'b0;
    repeat (30) begin
      step();
      if (bus.k_wake || bus.input_k != 0) wake_seen = 1'b1;
    end
    check("t2_glitch", 32'(wake_seen), 32'h0);

    // inverted released dpad up on row1 bit2
    clear_cfg();
    set_code(1, 2, 8'h80);
    bus.strobe = 8'h02;
    step(); step();
    check("t3_on", 32'(bus.input_k), 32'h4);
    bus.strobe = 8'h00;
    step();
    check("t3_lat", 32'(bus.input_k), 32'h4);
    step();
    check("t3_off", 32'(bus.input_k), 32'h0);

    // grounded row 3 -> row index 2
    clear_cfg();
    set_code(2, 3, 8'h0E);
    grounded_row = 4'd3;
    buttons_raw[10] = 1'b1;
    repeat (22) step();
    check("t4_ground", 32'(bus.input_k), 32'h8);
    grounded_row = 4'd9;
    step(); step();
    check("t4_oob", 32'(bus.input_k), 32'h0);
    grounded_row = 4'd0;

    // two strobes at once
    clear_cfg();
    buttons_raw[10] = 1'b0;
    buttons_raw[6]  = 1'b1;
    buttons_raw[7]  = 1'b1;
    set_code(0, 1, 8'h07);
    set_code(2, 3, 8'h06);
    bus.strobe = 8'b0000_0101;
    repeat (22) step();
    check("t5_multi", 32'(bus.input_k), 32'hA);

    // reset mid-debounce
    clear_cfg();
    buttons_raw = '0;
    set_code(0, 0, 8'h05);
    bus.strobe = 8'h01;
    repeat (25) step();
    buttons_raw[4] = 1'b1;
    repeat (10) step();
    reset_n = 1'b0;
    step();
    check("t6_rst_k",   32'(bus.input_k), 32'h0);
    check("t6_rst_aux", 32'({bus.input_acl, bus.input_ba, bus.input_beta}), 32'h0);
    reset_n = 1'b1;
    repeat (19) step();
    check("t6_early", 32'(bus.input_k), 32'h0);
    step();
    check("t6_full", 32'(bus.input_k), 32'h1);

    // randomized traffic
    for (int c = 0; c < 900; c++) begin
      if (c % 100 == 0) begin
        randomize_cfg();
        aux_config = {rand_code(), rand_code(), rand_code()};
      end
      if (c % 50 == 0) grounded_row = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) buttons_raw[$urandom_range(0, NB-1)] ^= 1'b1;
      bus.strobe = ($urandom_range(0, 3) == 0) ? '0 : NS'($urandom);
      reset_n = !(c >= 450 && c < 452);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
